// File: rtl/main_pkg.sv
// main_pkg: shared state encoding, operation bit indices and datapath width.
package main_pkg;
  localparam int WIDTH = 8;
  localparam logic [1:0] CLEAR = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;
  localparam logic [1:0] ERR   = 2'b11;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_XOR = 5;
endpackage

// File: rtl/main_alu_core.sv
// alu_core: one-hot selected combinational operation on two operands.
module alu_core
  import main_pkg::*;
#(
  parameter int WIDTH = main_pkg::WIDTH,
  parameter int W_OPS = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [W_OPS-1:0] out_sel,
  output logic [WIDTH-1:0] result
);
  localparam logic [W_OPS-1:0] ONE = W_OPS'(1);
  logic [WIDTH-1:0] w_mul;
  assign w_mul = a * b;
  // Zero, multi-hot and X-carrying selects match no item and fall to default.
  always_comb begin
    result = '0;
    case (out_sel)
      ONE << OP_ADD: result = a + b;
      ONE << OP_SUB: result = a - b;
      ONE << OP_MUL: result = w_mul;
      ONE << OP_AND: result = a & b;
      ONE << OP_OR:  result = a | b;
      ONE << OP_XOR: result = a ^ b;
      default:       result = '0;
    endcase
  end
endmodule

// File: rtl/main.sv
// main: command FSM with operand registers feeding a one-hot ALU.
module main
  import main_pkg::*;
#(
  parameter int WIDTH = main_pkg::WIDTH,
  parameter int W_OPS = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [W_OPS-1:0] out_sel,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [WIDTH-1:0] r_a, r_b, w_res;
  // Reset asserts immediately but releases only after two clk edges.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  always_comb begin
    nextState = ERR;
    case (in_sel)
      3'b001:         nextState = CLEAR;
      3'b010:         nextState = LOAD;
      3'b100, 3'b000: nextState = HOLD;
      default:        nextState = ERR;
    endcase
  end
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      currState <= CLEAR;
      r_a <= '0;
      r_b <= '0;
    end else begin
      currState <= nextState;
      r_a <= nextState == LOAD ? num1 : nextState == CLEAR ? '0 : r_a;
      r_b <= nextState == LOAD ? num2 : nextState == CLEAR ? '0 : r_b;
    end
  alu_core #(.WIDTH(WIDTH), .W_OPS(W_OPS)) u_alu (
    .a(r_a), .b(r_b), .out_sel(out_sel), .result(w_res)
  );
  assign out = (currState == LOAD || currState == HOLD) ? w_res : '0;
endmodule

// File: tb/tb_main.sv
// tb_main: directed checks of main's FSM, operand registers and ALU output.
module tb_main;
  logic       clk = 0, clk_en = 0, reset_n = 1;
  logic [2:0] in_sel = 3'b001;
  logic [7:0] num1 = 0, num2 = 0, out;
  logic [5:0] out_sel = 6'b000001;
  logic [1:0] currState, nextState;
  int tests = 0, fails = 0;
  main dut (
    .clk(clk), .reset_n(reset_n), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .out(out), .currState(currState), .nextState(nextState)
  );
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] exp_ops [6] = '{8'h71, 8'h3D, 8'hD6, 8'h12, 8'h5F, 8'h4D};
    #2 reset_n = 0;
    in_sel = 3'b010;
    #1;
    check("rst_state", 8'(currState), 8'h00);
    check("rst_out", out, 8'h00);
    check("rst_next_follows", 8'(nextState), 8'h01);
    in_sel = 3'b001;
    clk_en = 1;
    #7 reset_n = 1;
    repeat (4) tick();
    check("post_rst_clear", 8'(currState), 8'h00);
    in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = 6'b000001;
    tick();
    check("load_state", 8'(currState), 8'h01);
    for (int i = 0; i < 6; i++) begin
      out_sel = 6'(1 << i);
      #1;
      check($sformatf("op_bit%0d", i), out, exp_ops[i]);
    end
    out_sel = 6'b000011; #1;
    check("multi_hot", out, 8'h00);
    out_sel = 6'b000000; #1;
    check("zero_sel", out, 8'h00);
    out_sel = 6'bxxxxxx; #1;
    check("x_sel", out, 8'h00);
    out_sel = 6'b000001;
    in_sel = 3'b000; num1 = 8'h00; num2 = 8'h01; #1;
    check("next_hold", 8'(nextState), 8'h02);
    tick();
    check("hold_state", 8'(currState), 8'h02);
    check("hold_out", out, 8'h71);
    out_sel = 6'b000010; #1;
    check("hold_sel_change", out, 8'h3D);
    out_sel = 6'b000001;
    in_sel = 3'b011; #1;
    check("next_err", 8'(nextState), 8'h03);
    in_sel = 3'b111; #1;
    check("next_err_111", 8'(nextState), 8'h03);
    in_sel = 3'b011;
    tick();
    check("err_state", 8'(currState), 8'h03);
    check("err_out", out, 8'h00);
    in_sel = 3'b100;
    tick();
    check("err_to_hold", 8'(currState), 8'h02);
    check("err_retains", out, 8'h71);
    in_sel = 3'b001;
    tick();
    check("clear_state", 8'(currState), 8'h00);
    check("clear_out", out, 8'h00);
    out_sel = 6'b000011; #1;
    check("clear_sel", out, 8'h00);
    in_sel = 3'b000; out_sel = 6'b000001;
    tick();
    check("clear_zeroed", out, 8'h00);
    in_sel = 3'b010; num1 = 8'hFF; num2 = 8'h01;
    tick();
    check("add_wrap", out, 8'h00);
    out_sel = 6'b000010; #1;
    check("sub_ff", out, 8'hFE);
    in_sel = 3'b000; out_sel = 6'b000001;
    tick();
    check("hold_ff_add", out, 8'h00);
    out_sel = 6'b010000; #1;
    check("hold_ff_or", out, 8'hFF);
    #2 reset_n = 0; #1;
    check("midrst_state", 8'(currState), 8'h00);
    check("midrst_out", out, 8'h00);
    tick();
    reset_n = 1;
    repeat (4) tick();
    check("midrst_hold", 8'(currState), 8'h02);
    check("midrst_discard", out, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter WIDTH, default 8, datapath width of num1, num2 and out.
REQ-002 Parameter W_OPS, default 6, width of the one-hot operation select out_sel.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_sel  input  3  control command: bit2 persist, bit1 load, bit0 clear.
REQ-006 num1  input  WIDTH  operand A source.
REQ-007 num2  input  WIDTH  operand B source.
REQ-008 out_sel  input  W_OPS  one-hot operation select.
REQ-009 out  output  WIDTH  ALU result.
REQ-010 currState  output  2  registered FSM state.
REQ-011 nextState  output  2  combinational next FSM state.

Function
REQ-012 The FSM SHALL have states CLEAR=00, LOAD=01, HOLD=10 and ERR=11.
REQ-013 nextState SHALL be computed combinationally from in_sel only:
- 001 -> CLEAR
- 010 -> LOAD
- 100 or 000 -> HOLD
- any other value (two or more bits set) -> ERR
REQ-014 currState SHALL take the value of nextState on every rising clk edge.
REQ-015 Operand registers A and B SHALL load num1 and num2 on a rising edge when nextState==LOAD, and SHALL load again on every such edge.
REQ-016 A and B SHALL be cleared to 0 on a rising edge when nextState==CLEAR.
REQ-017 A and B SHALL hold their values when nextState is HOLD or ERR.
REQ-018 out SHALL be combinational from A, B, out_sel and currState, so a result is visible in the cycle after the load edge:
- out_sel bit0: A+B, carry discarded
- bit1: A-B, modulo 2^WIDTH
- bit2: low WIDTH bits of A*B
- bit3: A&B
- bit4: A|B
- bit5: A^B
REQ-019 out SHALL be 0 when out_sel is zero, not one-hot, or contains X.
REQ-020 out SHALL be 0 when currState is CLEAR or ERR.
REQ-021 A change of num1 or num2 while in HOLD SHALL NOT affect out.
REQ-022 A change of out_sel SHALL affect out immediately in every state except CLEAR and ERR.
REQ-023 From ERR, the next edge SHALL go to the state selected by in_sel; ERR itself has no stored error flag.

Reset
REQ-024 While reset_n=0:
- currState SHALL be CLEAR and A=B=0, applied immediately without waiting for clk.
- out SHALL be 0.
- nextState SHALL still follow in_sel.
REQ-025 Deassertion of reset_n SHALL be synchronised to clk.
REQ-026 The first edge after deassertion SHALL behave as a normal transition from CLEAR.
REQ-027 Reset asserted mid-operation SHALL discard A and B.

Structure
REQ-028 A shared package SHALL hold:
- the state encoding constants CLEAR, LOAD, HOLD and ERR
- the out_sel bit-index constants OP_ADD..OP_XOR
- WIDTH
REQ-029 The combinational operation unit SHALL be a sub-module alu_core (inputs A, B, out_sel; output result).
REQ-030 The FSM and the operand registers SHALL reside in main.

Verification
REQ-031 Assert reset_n=0 with clk stopped -> currState=00 and out=0 immediately.
REQ-032 Load num1=0x57, num2=0x1A (in_sel=010, one edge):
- currState=01
- out by out_sel bit: 000001=0x71, 000010=0x3D, 000100=0xD6, 001000=0x12, 010000=0x5F, 100000=0x4D
REQ-033 After the load, set in_sel=000, num1=0x00, num2=0x01 -> currState=10 and out stays 0x71 with ADD selected.
REQ-034 in_sel=011 -> nextState=11 at once; after the edge out=0; then in_sel=100 -> after the next edge out=0x71 (A and B retained).
REQ-035 in_sel=001 -> after the edge currState=00, A=B=0 and out=0; then out_sel=000011 -> out remains 0.
REQ-036 num1=0xFF, num2=0x01, load, out_sel=000001 -> out=0x00; out_sel=000010 -> out=0xFE.
